// File: rtl/axis_vid_par_pkg.sv
// Shared types for the AXI4-Stream video to parallel video timing path:
// sequencer states, the per-axis raster timing record and total/width helpers.
package axis_vid_par_pkg;

  typedef enum logic [1:0] {
    S_DROP = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vid_timing_t;

  localparam vid_timing_t H_TIMING_DEFAULT = '{active: 1920, fp: 88, sync: 44, bp: 148};
  localparam vid_timing_t V_TIMING_DEFAULT = '{active: 1080, fp: 4,  sync: 5,  bp: 36};

  // Clocks per line / lines per frame for one axis.
  function automatic int unsigned timing_total(input vid_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // Counter width able to hold 0..total-1 (never narrower than one bit).
  function automatic int unsigned counter_width(input int unsigned total);
    return (total > 32'd1) ? $clog2(total) : 32'd1;
  endfunction

endpackage

// File: rtl/vid_timing_gen.sv
// Free-running raster generator: h/v counters, per-position strobes for the
// sequencer and the registered de/hsync/vsync decode (one clock behind h,v).
module vid_timing_gen
  import axis_vid_par_pkg::*;
#(
  parameter vid_timing_t H_T      = H_TIMING_DEFAULT,
  parameter vid_timing_t V_T      = V_TIMING_DEFAULT,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_act,
  output logic o_first,
  output logic o_eol,
  output logic o_mid_line,
  output logic o_frame_end,
  output logic o_de,
  output logic o_hsync,
  output logic o_vsync
);

  localparam int unsigned H_TOTAL = timing_total(H_T);
  localparam int unsigned V_TOTAL = timing_total(V_T);
  localparam int unsigned HW      = counter_width(H_TOTAL);
  localparam int unsigned VW      = counter_width(V_TOTAL);

  // Range bounds carry one extra bit so a bound equal to TOTAL cannot wrap.
  localparam logic [HW:0]   H_ACT_END  = (HW+1)'(H_T.active);
  localparam logic [HW:0]   H_EOL_X    = (HW+1)'(H_T.active - 32'd1);
  localparam logic [HW:0]   H_SYNC_BEG = (HW+1)'(H_T.active + H_T.fp);
  localparam logic [HW:0]   H_SYNC_END = (HW+1)'(H_T.active + H_T.fp + H_T.sync);
  localparam logic [VW:0]   V_ACT_END  = (VW+1)'(V_T.active);
  localparam logic [VW:0]   V_SYNC_BEG = (VW+1)'(V_T.active + V_T.fp);
  localparam logic [VW:0]   V_SYNC_END = (VW+1)'(V_T.active + V_T.fp + V_T.sync);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 32'd1);
  localparam logic [HW-1:0] H_EOL      = HW'(H_T.active - 32'd1);
  localparam logic [HW-1:0] H_ONE      = HW'(32'd1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 32'd1);
  localparam logic [VW-1:0] V_ONE      = VW'(32'd1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [HW:0]   h_ext_s;
  logic [VW:0]   v_ext_s;
  logic          act_s;

  // Next raster position: h wraps every line and v advances on that wrap.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d = '0;
      end else begin
        v_d = v_q + V_ONE;
      end
    end else begin
      h_d = h_q + H_ONE;
    end
  end

  // Decode of the current position into strobes and next registered outputs.
  always_comb begin
    h_ext_s     = {1'b0, h_q};
    v_ext_s     = {1'b0, v_q};
    act_s       = (h_ext_s < H_ACT_END) && (v_ext_s < V_ACT_END);
    o_act       = act_s;
    o_first     = (h_q == '0) && (v_q == '0);
    o_eol       = (h_q == H_EOL);
    o_mid_line  = (h_ext_s < H_EOL_X);
    o_frame_end = (h_q == H_LAST) && (v_q == V_LAST);
    de_d        = act_s;
    hsync_d     = ((h_ext_s >= H_SYNC_BEG) && (h_ext_s < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d     = ((v_ext_s >= V_SYNC_BEG) && (v_ext_s < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  end

  // Counter and output registers with synchronous reset to the idle raster.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q     <= '0;
      v_q     <= '0;
      de_q    <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign o_de    = de_q;
  assign o_hsync = hsync_q;
  assign o_vsync = vsync_q;

endmodule

// File: rtl/axis_video_par_timing_ctrl.sv
// Sequencer for the AXI4-Stream video to parallel video path. Locks stream
// frames (tuser = SOF) to the raster, pulls beats only on active-pixel slots,
// and keeps sticky underflow / line-length error flags.
module axis_video_par_timing_ctrl
  import axis_vid_par_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_s_axis_video_tvalid,
  input  logic i_s_axis_video_tuser,
  input  logic i_s_axis_video_tlast,
  output logic o_s_axis_video_tready,
  output logic o_pix_load,
  output logic o_de,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_locked,
  output logic o_underflow,
  output logic o_eol_err,
  input  logic i_clr_err
);

  localparam vid_timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vid_timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

  state_t state_q, state_d;
  logic   underflow_q, underflow_d;
  logic   eol_err_q, eol_err_d;
  logic   tready_s;
  logic   uf_set_s;
  logic   eol_set_s;
  logic   act_s, first_s, eol_s, mid_line_s, frame_end_s;
  logic   tvalid_s, tuser_s, tlast_s;

  assign tvalid_s = i_s_axis_video_tvalid;
  assign tuser_s  = i_s_axis_video_tuser;
  assign tlast_s  = i_s_axis_video_tlast;

  vid_timing_gen #(
    .H_T      (H_T),
    .V_T      (V_T),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_act       (act_s),
    .o_first     (first_s),
    .o_eol       (eol_s),
    .o_mid_line  (mid_line_s),
    .o_frame_end (frame_end_s),
    .o_de        (o_de),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync)
  );

  // Lock FSM next state, stream ready and error-set strobes.
  always_comb begin
    state_d   = state_q;
    tready_s  = 1'b0;
    uf_set_s  = 1'b0;
    eol_set_s = 1'b0;
    case (state_q)
      S_DROP: begin
        // Discard anything that is not SOF; hold the SOF beat.
        tready_s = ~(tvalid_s & tuser_s);
        if (tvalid_s & tuser_s) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_DROP;
        end
      end
      S_WAIT: begin
        // SOF is held until the raster is about to start a new frame.
        if (frame_end_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RUN: begin
        // A SOF is only taken on the first pixel of a raster frame.
        tready_s = act_s & ~(tuser_s & ~first_s);
        if (act_s & ~tvalid_s) begin
          uf_set_s = 1'b1;
          state_d  = S_DROP;
        end else if (act_s & tuser_s & ~first_s) begin
          eol_set_s = 1'b1;
          state_d   = S_WAIT;
        end else if (act_s) begin
          // Beat consumed: tlast must mark exactly the last active pixel.
          if ((eol_s & ~tlast_s) | (tlast_s & mid_line_s)) begin
            eol_set_s = 1'b1;
          end else begin
            eol_set_s = 1'b0;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_DROP;
      end
    endcase
  end

  // Sticky flags: a new error in the same cycle as a clear keeps the flag set.
  always_comb begin
    if (uf_set_s) begin
      underflow_d = 1'b1;
    end else if (i_clr_err) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
    if (eol_set_s) begin
      eol_err_d = 1'b1;
    end else if (i_clr_err) begin
      eol_err_d = 1'b0;
    end else begin
      eol_err_d = eol_err_q;
    end
  end

  // State and flag registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_DROP;
      underflow_q <= 1'b0;
      eol_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      underflow_q <= underflow_d;
      eol_err_q   <= eol_err_d;
    end
  end

  assign o_s_axis_video_tready = tready_s;
  assign o_pix_load            = tvalid_s & tready_s;
  assign o_locked              = (state_q == S_RUN);
  assign o_underflow           = underflow_q;
  assign o_eol_err             = eol_err_q;

endmodule
